// File: rtl/s2_kes_dcme_pe_mc.sv
// s2_kes_dcme_pe_mc: multi-channel GF(2^M) DCME key-equation R/Q processing element with result capture
module s2_kes_dcme_pe_mc #(
   parameter int M = 8,
   parameter logic [M:0] PRIM = 9'h11D,
   parameter int NCH = 4,
   localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CW-1:0] ch,
   input  logic [2:0]    op,
   input  logic          last,
   input  logic [M-1:0]  r_init,
   input  logic [M-1:0]  q_init,
   input  logic [M-1:0]  r_in,
   input  logic [M-1:0]  q_in,
   input  logic [M-1:0]  a,
   input  logic [M-1:0]  b,
   output logic [M-1:0]  r_out,
   output logic [M-1:0]  q_out,
   output logic [M-1:0]  r_final,
   output logic [M-1:0]  res_data,
   output logic [CW-1:0] res_ch,
   output logic          res_vld,
   output logic          ch_err
);
   localparam logic [2:0] OP_NOP = 3'd0, OP_INIT = 3'd1, OP_SHR = 3'd2, OP_SHQ = 3'd3, OP_SWAP = 3'd4, OP_UPD = 3'd5;
   function automatic logic [M-1:0] gfmul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [M-1:0] p;
      p = '0;
      for (int i = M - 1; i >= 0; i--)
         p = (p[M-1] ? ((p << 1) ^ PRIM[M-1:0]) : (p << 1)) ^ (y[i] ? x : '0);
      return p;
   endfunction
   logic [NCH-1:0][M-1:0] r_q, q_q;
   logic ch_ok, cap;
   logic [M-1:0] r_cur, q_cur, r_upd, r_nxt, q_nxt;
   logic [2:0] op_e;
   assign ch_ok = {1'b0, ch} < (CW + 1)'(NCH);
   always_comb begin
      r_cur = ch_ok ? r_q[ch] : '0;
      q_cur = ch_ok ? q_q[ch] : '0;
      r_upd = gfmul(b, r_in) ^ gfmul(a, q_in);
      op_e = (en && ch_ok) ? op : OP_NOP;
      r_nxt = op_e == OP_INIT ? r_init : op_e == OP_SHR ? r_in : (op_e == OP_SWAP || op_e == OP_UPD) ? r_upd : r_cur;
      q_nxt = op_e == OP_INIT ? q_init : op_e == OP_SHQ ? q_in : op_e == OP_SWAP ? r_cur : q_cur;
      cap = en && last && ch_ok && (op == OP_SWAP || op == OP_UPD);
   end
   assign r_out = r_cur;
   assign q_out = q_cur;
   assign r_final = r_nxt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
         q_q <= '0;
         res_data <= '0;
         res_ch <= '0;
         res_vld <= 1'b0;
         ch_err <= 1'b0;
      end else begin
         if (en && ch_ok) begin
            r_q[ch] <= r_nxt;
            q_q[ch] <= q_nxt;
         end
         res_vld <= cap;
         ch_err <= !ch_ok;
         if (cap) begin
            res_data <= r_nxt;
            res_ch <= ch;
         end
      end
   end
endmodule

// File: tb/tb_s2_kes_dcme_pe_mc.sv
// tb_s2_kes_dcme_pe_mc: scoreboard bench covering reset, arithmetic, capture, interleave, range and parameters
module tb_s2_kes_dcme_pe_mc;
   logic clk = 0, rst = 1, en = 0, last = 0;
   logic [1:0] ch = 0;
   logic [2:0] op = 0;
   logic [7:0] r_init = 0, q_init = 0, r_in = 0, q_in = 0, a = 0, b = 0;
   logic [7:0] r_out8, q_out8, r_final8, res_data8, r_out3, q_out3, r_final3, res_data3;
   logic [3:0] r_out4, q_out4, r_final4, res_data4;
   logic [1:0] res_ch8, res_ch3, res_ch4;
   logic res_vld8, ch_err8, res_vld3, ch_err3, res_vld4, ch_err4;
   int pass = 0, total = 0;
   logic [7:0] mr [4], mq [4];
   logic [9:0] exp_q [$];
   logic [9:0] e;
   always #5 clk = ~clk;
   s2_kes_dcme_pe_mc #(.M(8), .PRIM(9'h11D), .NCH(4)) u8 (
      .clk(clk), .rst(rst), .en(en), .ch(ch), .op(op), .last(last), .r_init(r_init), .q_init(q_init),
      .r_in(r_in), .q_in(q_in), .a(a), .b(b), .r_out(r_out8), .q_out(q_out8), .r_final(r_final8),
      .res_data(res_data8), .res_ch(res_ch8), .res_vld(res_vld8), .ch_err(ch_err8));
   s2_kes_dcme_pe_mc #(.M(8), .PRIM(9'h11D), .NCH(3)) u3 (
      .clk(clk), .rst(rst), .en(en), .ch(ch), .op(op), .last(last), .r_init(r_init), .q_init(q_init),
      .r_in(r_in), .q_in(q_in), .a(a), .b(b), .r_out(r_out3), .q_out(q_out3), .r_final(r_final3),
      .res_data(res_data3), .res_ch(res_ch3), .res_vld(res_vld3), .ch_err(ch_err3));
   s2_kes_dcme_pe_mc #(.M(4), .PRIM(5'h13), .NCH(4)) u4 (
      .clk(clk), .rst(rst), .en(en), .ch(ch), .op(op), .last(last), .r_init(r_init[3:0]), .q_init(q_init[3:0]),
      .r_in(r_in[3:0]), .q_in(q_in[3:0]), .a(a[3:0]), .b(b[3:0]), .r_out(r_out4), .q_out(q_out4), .r_final(r_final4),
      .res_data(res_data4), .res_ch(res_ch4), .res_vld(res_vld4), .ch_err(ch_err4));
   function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p, t;
      p = 0;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p ^= t;
         t = t[7] ? ((t << 1) ^ 8'h1D) : (t << 1);
      end
      return p;
   endfunction
   task automatic predict(output logic [7:0] rn, output logic [7:0] qn);
      logic [7:0] up;
      up = gm(b, r_in) ^ gm(a, q_in);
      rn = mr[ch];
      qn = mq[ch];
      if (en)
         case (op)
            3'd1: begin rn = r_init; qn = q_init; end
            3'd2: rn = r_in;
            3'd3: qn = q_in;
            3'd4: begin qn = mr[ch]; rn = up; end
            3'd5: rn = up;
            default: ;
         endcase
   endtask
   task automatic tick();
      logic [7:0] rn, qn;
      logic [1:0] c;
      predict(rn, qn);
      c = ch;
      if (en && last && (op == 3'd4 || op == 3'd5)) exp_q.push_back({c, rn});
      @(posedge clk);
      mr[c] = rn;
      mq[c] = qn;
      #1;
   endtask
   task automatic setop(input logic [1:0] c, input logic [2:0] o, input logic l);
      ch = c;
      op = o;
      last = l;
      en = 1;
   endtask
   always @(negedge clk)
      if (!rst && res_vld8) begin
         total++;
         if (exp_q.size() == 0) $display("FAIL sb_extra: res_vld with ch %0d data %h, nothing expected", res_ch8, res_data8);
         else begin
            e = exp_q.pop_front();
            if ({res_ch8, res_data8} !== e) $display("FAIL sb_result: got ch %0d data %h, want ch %0d data %h", res_ch8, res_data8, e[9:8], e[7:0]);
            else pass++;
         end
      end
   task automatic test_reset();
      rst = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         setop(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         r_init = 8'($urandom); q_init = 8'($urandom); r_in = 8'($urandom); q_in = 8'($urandom);
      end
      #1;
      total++; if (r_out8 !== 0 || q_out8 !== 0) $display("FAIL rst_hold_rq: got %h/%h want 00/00", r_out8, q_out8); else pass++;
      total++; if (res_vld8 !== 0 || ch_err8 !== 0) $display("FAIL rst_hold_flags: got %b/%b want 0/0", res_vld8, ch_err8); else pass++;
      rst = 0;
      setop(0, 0, 0);
      #1;
      total++; if (r_out8 !== 0 || q_out8 !== 0) $display("FAIL rst_rel_rq: got %h/%h want 00/00", r_out8, q_out8); else pass++;
      total++; if (r_final8 !== 0) $display("FAIL rst_rel_rfinal: got %h want 00", r_final8); else pass++;
      total++; if (res_vld8 !== 0 || ch_err8 !== 0) $display("FAIL rst_rel_flags: got %b/%b want 0/0", res_vld8, ch_err8); else pass++;
      for (int i = 0; i < 4; i++) begin mr[i] = 0; mq[i] = 0; end
      tick();
   endtask
   task automatic test_update();
      setop(1, 1, 0); r_init = 8'h33; q_init = 8'h44;
      tick();
      setop(1, 5, 0); a = 8'h02; q_in = 8'h80; b = 8'h03; r_in = 8'h05;
      #1;
      total++; if (r_final8 !== 8'h12) $display("FAIL upd_rfinal: got %h want 12", r_final8); else pass++;
      tick();
      setop(1, 0, 0);
      #1;
      total++; if (r_out8 !== 8'h12 || q_out8 !== 8'h44) $display("FAIL upd_rq: got %h/%h want 12/44", r_out8, q_out8); else pass++;
   endtask
   task automatic test_swap();
      setop(2, 1, 0); r_init = 8'h33; q_init = 8'h77;
      tick();
      setop(2, 4, 1); a = 8'h02; q_in = 8'h80; b = 8'h03; r_in = 8'h05;
      tick();
      setop(2, 0, 0);
      #1;
      total++; if (r_out8 !== 8'h12 || q_out8 !== 8'h33) $display("FAIL swap_rq: got %h/%h want 12/33", r_out8, q_out8); else pass++;
      total++; if (res_vld8 !== 1 || res_data8 !== 8'h12 || res_ch8 !== 2) $display("FAIL swap_res: got vld %b data %h ch %0d want 1 12 2", res_vld8, res_data8, res_ch8); else pass++;
      tick();
      total++; if (res_vld8 !== 0) $display("FAIL swap_pulse: res_vld got %b want 0", res_vld8); else pass++;
   endtask
   task automatic test_interleave();
      setop(0, 1, 0); r_init = 8'h11; q_init = 8'h22; tick();
      setop(3, 1, 0); r_init = 8'h66; q_init = 8'h77; tick();
      for (int i = 0; i < 2; i++) begin
         setop(0, 2, 0); r_in = 8'hA5; tick();
         if (i == 0)
            for (int s = 0; s < 2; s++) begin
               setop(1, 1, 1); en = 0; r_init = 8'hFF; q_init = 8'hEE;
               tick();
               total++; if (r_out8 !== mr[1] || q_out8 !== mq[1]) $display("FAIL stall_hold: got %h/%h want %h/%h", r_out8, q_out8, mr[1], mq[1]); else pass++;
            end
         setop(3, 3, 0); q_in = 8'h5A; tick();
      end
      for (int c = 0; c < 4; c++) begin
         setop(2'(c), 0, 0);
         #1;
         total++; if (r_out8 !== mr[c] || q_out8 !== mq[c]) $display("FAIL il_bank%0d: got %h/%h want %h/%h", c, r_out8, q_out8, mr[c], mq[c]); else pass++;
      end
      setop(0, 0, 0); #1;
      total++; if (r_out8 !== 8'hA5 || q_out8 !== 8'h22) $display("FAIL il_ch0: got %h/%h want a5/22", r_out8, q_out8); else pass++;
      setop(3, 0, 0); #1;
      total++; if (r_out8 !== 8'h66 || q_out8 !== 8'h5A) $display("FAIL il_ch3: got %h/%h want 66/5a", r_out8, q_out8); else pass++;
   endtask
   task automatic test_out_of_range();
      for (int c = 0; c < 3; c++) begin
         setop(2'(c), 1, 0); r_init = 8'(8'h10 + c); q_init = 8'(8'h20 + c); tick();
      end
      setop(3, 1, 0); r_init = 8'h99; q_init = 8'hAA;
      #1;
      total++; if (r_out3 !== 0 || q_out3 !== 0 || r_final3 !== 0) $display("FAIL oor_read: got %h/%h/%h want 00/00/00", r_out3, q_out3, r_final3); else pass++;
      tick();
      total++; if (ch_err3 !== 1) $display("FAIL oor_err_set: got %b want 1", ch_err3); else pass++;
      setop(0, 0, 0);
      tick();
      total++; if (ch_err3 !== 0) $display("FAIL oor_err_clr: got %b want 0", ch_err3); else pass++;
      for (int c = 0; c < 3; c++) begin
         setop(2'(c), 0, 0);
         #1;
         total++; if (r_out3 !== 8'(8'h10 + c) || q_out3 !== 8'(8'h20 + c)) $display("FAIL oor_bank%0d: got %h/%h want %h/%h", c, r_out3, q_out3, 8'(8'h10 + c), 8'(8'h20 + c)); else pass++;
      end
   endtask
   task automatic test_back_to_back();
      logic [7:0] rn, qn;
      for (int i = 0; i < 32; i++) begin
         setop(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         en = ($urandom_range(0, 4) != 0);
         r_init = 8'($urandom); q_init = 8'($urandom); r_in = 8'($urandom); q_in = 8'($urandom);
         a = 8'($urandom); b = 8'($urandom);
         if (i % 8 == 7) ch = 2'(i / 8);
         predict(rn, qn);
         #1;
         total++; if (r_final8 !== rn) $display("FAIL b2b_rfinal%0d: got %h want %h", i, r_final8, rn); else pass++;
         tick();
         total++; if (r_out8 !== mr[ch] || q_out8 !== mq[ch]) $display("FAIL b2b_rq%0d: got %h/%h want %h/%h", i, r_out8, q_out8, mr[ch], mq[ch]); else pass++;
      end
      setop(0, 0, 0);
      tick();
   endtask
   task automatic test_reset_mid();
      setop(1, 1, 0); r_init = 8'h33; q_init = 8'h44; tick();
      setop(1, 5, 1); a = 8'h02; q_in = 8'h80; b = 8'h03; r_in = 8'h05; tick();
      setop(1, 0, 0);
      total++; if (res_vld8 !== 1) $display("FAIL rmid_vld_pre: got %b want 1", res_vld8); else pass++;
      @(negedge clk);
      #1;
      rst = 1;
      #1;
      total++; if (res_vld8 !== 0) $display("FAIL rmid_vld_drop: got %b want 0", res_vld8); else pass++;
      total++; if (r_out8 !== 0 || q_out8 !== 0) $display("FAIL rmid_rq: got %h/%h want 00/00", r_out8, q_out8); else pass++;
      for (int i = 0; i < 4; i++) begin mr[i] = 0; mq[i] = 0; end
      @(posedge clk);
      #1;
      rst = 0;
   endtask
   task automatic test_param();
      setop(1, 5, 0); a = 8'h02; q_in = 8'h08; b = 8'h01; r_in = 8'h00;
      #1;
      total++; if (r_final4 !== 4'h3) $display("FAIL m4_rfinal: got %h want 3", r_final4); else pass++;
      total++; if (r_final8 !== 8'h10) $display("FAIL m8_rfinal: got %h want 10", r_final8); else pass++;
      tick();
      setop(1, 0, 0);
      #1;
      total++; if (r_out4 !== 4'h3 || q_out4 !== 4'h0) $display("FAIL m4_rq: got %h/%h want 3/0", r_out4, q_out4); else pass++;
   endtask
   initial begin
      test_reset();
      test_update();
      test_swap();
      test_interleave();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      test_param();
      repeat (2) @(posedge clk);
      total++; if (exp_q.size() !== 0) $display("FAIL sb_missing: %0d results still expected, want 0", exp_q.size()); else pass++;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/s2_kes_dcme_pe_mc.md
# s2_kes_dcme_pe_mc

Parametrised, multi-channel processing element for the DCME key-equation solver in stage 2 (KES) of the RS decoder. It generalises the single-channel GF(2^8) R/Q cell in three ways: field width and polynomial are parameters, NCH codewords share one PE through time-interleaved per-channel register banks, and a stall enable is added. Completed R results are captured into a registered result port with a valid pulse. Instances chain systolically: each PE's r_out and q_out feed the next PE's r_in and q_in for the same channel.

## Interface
- M, 8: symbol width; arithmetic is in GF(2^M).
- PRIM, 9'h11D: primitive polynomial, M+1 bits, MSB set.
- NCH, 4: number of interleaved channels, 1..16.
- CW, max(1, clog2(NCH)): channel index width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  operation enable; 0 = stall.
- ch  in  CW  channel the current cycle operates on.
- op  in  3  0 NOP, 1 INIT, 2 SHIFT_R, 3 SHIFT_Q, 4 SWAP, 5 UPDATE; codes 6 and 7 behave as NOP.
- last  in  1  marks the final UPDATE/SWAP of a channel's iteration.
- r_init, q_init  in  M  load values for INIT.
- r_in, q_in  in  M  values from the neighbouring PE.
- a, b  in  M  DCME coefficients.
- r_out, q_out  out  M  R[ch] and Q[ch], combinational read of the registers.
- r_final  out  M  R_next of the selected channel (combinational).
- res_data  out  M  captured result.
- res_ch  out  CW  channel of res_data.
- res_vld  out  1  one-cycle result pulse.
- ch_err  out  1  registered flag: ch was out of range.

## Operation
- Storage: register banks R[0..NCH-1] and Q[0..NCH-1], each M bits. Only entry ch may change in a cycle.
- R_update = gfmul(b, r_in) XOR gfmul(a, q_in).
  - gfmul is a combinational carry-less product reduced modulo PRIM.
  - With M=8 and PRIM=11D it must be bit-identical to the existing gf2m8_multi.
- R_next / Q_next for channel ch when en=1:
  - INIT: r_init / q_init.
  - SHIFT_R: r_in / Q[ch].
  - SHIFT_Q: R[ch] / q_in.
  - SWAP: R_update / R[ch].
  - UPDATE: R_update / Q[ch].
  - NOP: R[ch] / Q[ch].
- If en=0, R_next = R[ch] and Q_next = Q[ch]. No register changes.
- Out-of-range channel (ch ≥ NCH, only possible when NCH is not a power of 2):
  - The operation is forced to NOP.
  - r_out, q_out and r_final read 0.
  - ch_err is set to 1 on the next edge. Otherwise ch_err is 0 on that edge.
- Result capture: when en=1, last=1, op∈{SWAP, UPDATE} and ch is in range:
  - On the edge: res_data ← R_next, res_ch ← ch, res_vld ← 1.
  - Otherwise res_vld ← 0, and res_data / res_ch hold.
  - last with any other op is ignored.
- Reset (asynchronous assert, release synchronised externally): all R, Q, res_data, res_ch, res_vld and ch_err go to 0 immediately. r_out, q_out and r_final therefore read 0 once rst is applied.

## Timing
- All register updates happen on the rising edge. r_out and q_out reflect the new value in the cycle after the edge.
- r_final is zero-latency (combinational in the same cycle). res_data/res_vld have 1-cycle latency.
- Back-to-back ops on different channels every cycle are legal with no bubbles. Channels are fully independent.
- Back-to-back ops on the same channel are legal; the second op sees the first op's result.
- A stall (en=0) freezes all state. Ops resume correctly in the cycle after en returns to 1.
- rst asserted mid-iteration aborts all channels. A pending res_vld is dropped in the same cycle.
- The combinational path r_in/q_in → r_final passes through exactly one gfmul and one XOR.

## Test plan
- Reset: hold rst with arbitrary inputs; then release, ch=0, op=NOP → r_out=q_out=r_final=0, res_vld=0, ch_err=0.
- Update arithmetic (M=8): INIT ch1 with r_init=0x33, q_init=0x44; then UPDATE ch1 with a=0x02, q_in=0x80, b=0x03, r_in=0x05.
  - Same cycle: r_final=0x12 (0x1D^0x0F).
  - Next cycle: r_out=0x12, q_out=0x44.
- Swap with result capture: SWAP ch2 after INIT ch2 with r_init=0x33, same a/b/r_in/q_in as above, last=1.
  - Next cycle: R[2]=0x12, Q[2]=0x33, res_data=0x12, res_ch=2, res_vld=1 for exactly 1 cycle.
- Interleave and stall: alternate SHIFT_R on ch0 (r_in=0xA5) and SHIFT_Q on ch3 (q_in=0x5A), with en=0 inserted for 2 cycles.
  - Expect R[0]=0xA5 and Q[3]=0x5A, with all other entries unchanged.
  - No state changes during the stall.
- Out of range (NCH=3): INIT on ch=3 → no bank changes, r_out=0, ch_err=1 for one cycle.
- Reset mid-operation and parameter sweep:
  - Assert rst in the cycle res_vld=1 → res_vld drops to 0 immediately.
  - Rerun the arithmetic scenario with M=4, PRIM=5'h13: a=0x2, q_in=0x8, b=0x1, r_in=0x0 → r_final=0x3.
